agg_rr_arbiter: RTL and testbench
=================================

# agg_rr_arbiter

Round-robin arbiter and select sequencer for a shared 4:1 aggregation mux. Up to four requesters compete for the mux. The block grants one at a time and drives the mux's 2-bit concatenated selector as two scalar bits, `sel_a` (MSB) and `sel_b` (LSB). The downstream mux decodes `{sel_a,sel_b}`. A hold counter bounds grant tenure, and a one-cycle switch gap keeps the mux output stable across ownership changes.

## Interface

Parameters:
- `MAX_HOLD`, default 8: maximum consecutive GRANT cycles for one owner while another requester is pending; legal range 1..2^CNT_W.
- `CNT_W`, default 4: hold counter width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req`  in  4  request vector; bit i belongs to requester i; level-sensitive.
- `lock`  in  1  tenure-extension request from the current owner (present only with `AGG_ARB_LOCK_EN`).
- `grant`  out  4  one-hot grant, or all zero.
- `sel_a`  out  1  mux select MSB; owner index bit 1.
- `sel_b`  out  1  mux select LSB; owner index bit 0.
- `busy`  out  1  high in GRANT and SWITCH.

## Operation

- Registered state:
  - FSM with states IDLE, GRANT and SWITCH.
  - 2-bit `owner`.
  - `hold_cnt[CNT_W-1:0]`.
- Round-robin search:
  - Starts at `owner+1` (mod 4) and picks the first set `req` bit.
  - After reset, `owner`=3, so requester 0 wins first.
- IDLE:
  - If `req`≠0: select the winner, load `owner`, clear `hold_cnt`, go to GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - `grant[owner]`=1 and `{sel_a,sel_b}`=`owner`.
  - `hold_cnt` increments each cycle and saturates at `MAX_HOLD-1`.
  - If `req[owner]`=0, go to SWITCH.
  - Else if `hold_cnt`=`MAX_HOLD-1` and any other `req` bit is set, go to SWITCH (forced rotation).
  - Else if `hold_cnt`=`MAX_HOLD-1` and no other requester is pending, stay in GRANT and reset `hold_cnt` to 0. The sole requester keeps the mux.
- SWITCH:
  - `grant`=0; `sel_a`/`sel_b` hold the previous owner's value.
  - If `req`≠0, run the search from `owner+1` using the current `req`, load the new `owner`, clear `hold_cnt`, go to GRANT.
  - Otherwise go to IDLE.
  - A requester that just released may win again only if no one else is requesting.
- `sel_a`/`sel_b` change only on entry to GRANT. They retain their value in IDLE and SWITCH.
- `busy` = (state≠IDLE).

## Timing

- Reset values: `grant`=4'b0000, `sel_a`=0, `sel_b`=0, `busy`=0, state=IDLE, `owner`=3, `hold_cnt`=0.
- Grant latency: `req` sampled at edge N while in IDLE gives `grant` at N+1 (one cycle).
- Handoff latency: the last GRANT cycle is followed by exactly one SWITCH cycle with `grant`=0. The next `grant` appears the following cycle.
- Maximum tenure under contention: `MAX_HOLD` cycles with `grant` high.
- Worst-case wait for a requester holding `req` high: 3·(`MAX_HOLD`+1) cycles.
- Simultaneous events:
  - If `req[owner]` drops in the same cycle that `hold_cnt` hits its limit, go to SWITCH. This is treated as a single transition.
  - Requests arriving during SWITCH are included in that cycle's search.
- Reset mid-operation: `rst_n`=0 sampled at any edge forces all reset values at that edge. This applies in any state, with no partial handoff.
- `grant` and `sel_*` are registered outputs with no combinational path from `req`.

## Configuration

- Macro: `AGG_ARB_LOCK_EN`.
- Defined:
  - The `lock` port exists.
  - In GRANT with `lock`=1 and `req[owner]`=1, forced rotation is suppressed and `hold_cnt` is held at `MAX_HOLD-1`.
  - Releasing `lock` while others are pending causes SWITCH on the next edge.
  - `lock` is ignored outside GRANT.
- Not defined:
  - No `lock` port.
  - Rotation is purely counter-driven as described in Operation.

## Test plan

- Reset, then `req`=4'b0100 at cycle 1 → `grant`=4'b0100 and `{sel_a,sel_b}`=2'b10 at cycle 2; `busy`=1.
- `req`=4'b1111 held for 40 cycles with `MAX_HOLD`=8 → grants in order 0,1,2,3,0. Each tenure is 8 cycles, separated by one `grant`=0 cycle; the sel bits remain stable in gap cycles.
- Sole requester 3 held for 20 cycles → `grant`=4'b1000 continuously, with no SWITCH cycles.
- Owner 1 drops `req` while requester 0 is pending → one SWITCH cycle, then `grant`=4'b0001. The search wraps past 2 and 3.
- `rst_n`=0 asserted for one cycle while in GRANT → next edge gives `grant`=0, sel=00, `busy`=0. With `req`=4'b1111 afterward, requester 0 wins first.
- With `AGG_ARB_LOCK_EN` defined, owner 2 holds `lock`=1 for 15 cycles with `req`=4'b1111 → `grant`=4'b0100 for all 15 cycles. Dropping `lock` gives SWITCH, then `grant`=4'b1000.

Source files
------------

// File: rtl/agg_rr_arbiter.sv
// Round-robin arbiter and 2-bit select sequencer for a shared 4:1 aggregation mux.
// Optional macro AGG_ARB_LOCK_EN adds the owner's lock input for tenure extension.
module agg_rr_arbiter #(
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
`ifdef AGG_ARB_LOCK_EN
   input  logic       lock,
`endif
   output logic [3:0] grant,
   output logic       sel_a,
   output logic       sel_b,
   output logic       busy
);

   localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_GRANT,
      ST_SWITCH
   } state_t;

   state_t           state_reg, state_next;
   logic [1:0]       owner_reg, owner_next;
   logic [CNT_W-1:0] hold_cnt_reg, hold_cnt_next;
   logic [3:0]       grant_reg, grant_next;
   logic [1:0]       sel_reg, sel_next;

   logic [3:0] rot_req;
   logic [1:0] win_off;
   logic [1:0] winner;
   logic [3:0] owner_onehot;
   logic       others_pending;
   logic       owner_req;
   logic       at_limit;
   logic       lock_hold;

   // rot_req[k] is the request of requester owner+1+k, so bit 0 has top priority.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_rot
         assign rot_req[gi] = req[owner_reg + 2'(gi + 1)];
      end
   endgenerate

   always_comb begin
      win_off = 2'd3;
      if (rot_req[0])      win_off = 2'd0;
      else if (rot_req[1]) win_off = 2'd1;
      else if (rot_req[2]) win_off = 2'd2;
   end

   assign winner         = owner_reg + win_off + 2'd1;
   assign owner_onehot   = 4'b0001 << owner_reg;
   assign others_pending = |(req & ~owner_onehot);
   assign owner_req      = |(req & owner_onehot);
   assign at_limit       = (hold_cnt_reg == HOLD_LIM);

`ifdef AGG_ARB_LOCK_EN
   assign lock_hold = lock;
`else
   assign lock_hold = 1'b0;
`endif

   always_comb begin
      state_next    = state_reg;
      owner_next    = owner_reg;
      hold_cnt_next = hold_cnt_reg;
      grant_next    = grant_reg;
      sel_next      = sel_reg;
      case (state_reg)
         ST_IDLE, ST_SWITCH: begin
            if (|req) begin
               state_next    = ST_GRANT;
               owner_next    = winner;
               hold_cnt_next = '0;
               grant_next    = 4'b0001 << winner;
               sel_next      = winner;
            end else begin
               state_next = ST_IDLE;
            end
         end
         ST_GRANT: begin
            if (!owner_req) begin
               state_next = ST_SWITCH;
               grant_next = 4'b0000;
            end else if (lock_hold) begin
               // Locked owner keeps the mux; counter parks at the limit so
               // releasing lock under contention rotates on the next edge.
               hold_cnt_next = at_limit ? HOLD_LIM : hold_cnt_reg + CNT_W'(1);
            end else if (at_limit && others_pending) begin
               state_next = ST_SWITCH;
               grant_next = 4'b0000;
            end else if (at_limit) begin
               hold_cnt_next = '0;
            end else begin
               hold_cnt_next = hold_cnt_reg + CNT_W'(1);
            end
         end
         default: begin
            state_next = ST_IDLE;
            grant_next = 4'b0000;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg    <= ST_IDLE;
         owner_reg    <= 2'd3;
         hold_cnt_reg <= '0;
         grant_reg    <= 4'b0000;
         sel_reg      <= 2'd0;
      end else begin
         state_reg    <= state_next;
         owner_reg    <= owner_next;
         hold_cnt_reg <= hold_cnt_next;
         grant_reg    <= grant_next;
         sel_reg      <= sel_next;
      end
   end

   assign grant = grant_reg;
   assign sel_a = sel_reg[1];
   assign sel_b = sel_reg[0];
   assign busy  = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_agg_rr_arbiter.sv
// Randomized and directed bench for agg_rr_arbiter against a tenure-level model.
module tb_agg_rr_arbiter;

   localparam int MAX_HOLD = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req = 4'b0000;
   logic       lock = 1'b0;
   logic [3:0] grant;
   logic       sel_a, sel_b, busy;

   int n_checks = 0;
   int n_fail   = 0;
   bit check_en = 1'b0;

   // Model: 0 = idle, 1 = granting, 2 = gap cycle
   int m_state = 0, m_owner = 3, m_held = 0, m_sel = 0;

   agg_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
`ifdef AGG_ARB_LOCK_EN
      .lock  (lock),
`endif
      .grant (grant),
      .sel_a (sel_a),
      .sel_b (sel_b),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   function automatic int pick(int own, logic [3:0] r);
      for (int k = 1; k <= 4; k++) begin
         if (r[(own + k) % 4]) return (own + k) % 4;
      end
      return own;
   endfunction

   always @(posedge clk) begin : model
      int st, own, held, sl;
      logic lk;
      st = m_state; own = m_owner; held = m_held; sl = m_sel;
`ifdef AGG_ARB_LOCK_EN
      lk = lock;
`else
      lk = 1'b0;
`endif
      if (!rst_n) begin
         st = 0; own = 3; held = 0; sl = 0;
      end else if (st == 1) begin
         if (!req[own]) st = 2;
         else if (lk) held = (held >= MAX_HOLD) ? MAX_HOLD : held + 1;
         else if (held >= MAX_HOLD && (req & ~(4'b0001 << own)) != 4'b0000) st = 2;
         else if (held >= MAX_HOLD) held = 1;
         else held = held + 1;
      end else if (req != 4'b0000) begin
         own = pick(own, req); sl = own; held = 1; st = 1;
      end else begin
         st = 0;
      end
      m_state <= st; m_owner <= own; m_held <= held; m_sel <= sl;
   end

   task automatic chk(string name, int actual, int expected);
      n_checks++;
      if (actual != expected) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
      end
   endtask

   always @(negedge clk) begin
      if (check_en) begin
         logic [3:0] exp_g;
         exp_g = (m_state == 1) ? 4'(1 << m_owner) : 4'd0;
         chk("model_grant", int'(grant), int'(exp_g));
         chk("model_sel", int'({sel_a, sel_b}), m_sel);
         chk("model_busy", int'(busy), (m_state != 0) ? 1 : 0);
         $display("cyc t=%0t req=%b grant=%b sel=%0d busy=%0d", $time, req, grant, {sel_a, sel_b}, busy);
      end
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; req = 4'b0000; lock = 1'b0;
      cyc();
      rst_n = 1'b1;
   endtask

   initial begin
      cyc(); cyc();
      check_en = 1'b1;
      chk("reset_grant", int'(grant), 0);
      chk("reset_sel", int'({sel_a, sel_b}), 0);
      chk("reset_busy", int'(busy), 0);

      // Single requester 2: one-cycle grant latency
      rst_n = 1'b1; req = 4'b0100;
      cyc();
      chk("first_grant", int'(grant), 4'b0100);
      chk("first_sel", int'({sel_a, sel_b}), 2);
      chk("first_busy", int'(busy), 1);

      // Full contention: 8-cycle tenures, 1-cycle gaps, order 0,1,2,3,0
      do_reset();
      req = 4'b1111;
      for (int c = 1; c <= 40; c++) begin
         int p, o;
         cyc();
         p = (c - 1) % 9;
         o = ((c - 1) / 9) % 4;
         chk("rr_grant", int'(grant), (p == 8) ? 0 : (1 << o));
         if (p == 8) chk("rr_gap_sel", int'({sel_a, sel_b}), o);
      end

      // Sole requester 3 keeps the mux with no gaps
      do_reset();
      req = 4'b1000;
      for (int c = 0; c < 20; c++) begin
         cyc();
         chk("sole_grant", int'(grant), 4'b1000);
      end

      // Owner 1 releases, search wraps to requester 0
      do_reset();
      req = 4'b0010;
      cyc();
      chk("own1_grant", int'(grant), 4'b0010);
      req = 4'b0001;
      cyc();
      chk("wrap_gap_grant", int'(grant), 0);
      chk("wrap_gap_sel", int'({sel_a, sel_b}), 1);
      cyc();
      chk("wrap_grant", int'(grant), 4'b0001);

      // Reset in the middle of a tenure
      req = 4'b1111;
      cyc();
      rst_n = 1'b0;
      cyc();
      chk("midrst_grant", int'(grant), 0);
      chk("midrst_sel", int'({sel_a, sel_b}), 0);
      chk("midrst_busy", int'(busy), 0);
      rst_n = 1'b1;
      cyc();
      chk("post_rst_grant", int'(grant), 4'b0001);

`ifdef AGG_ARB_LOCK_EN
      do_reset();
      req = 4'b0100; lock = 1'b1;
      cyc();
      chk("lock_grant", int'(grant), 4'b0100);
      req = 4'b1111;
      for (int c = 0; c < 14; c++) begin
         cyc();
         chk("lock_grant", int'(grant), 4'b0100);
      end
      lock = 1'b0;
      cyc();
      chk("unlock_gap", int'(grant), 0);
      cyc();
      chk("unlock_next", int'(grant), 4'b1000);
`endif

      // Randomized traffic with sticky requests and rare resets
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         logic [3:0] flip;
         flip = 4'b0000;
         for (int b = 0; b < 4; b++) flip[b] = ($urandom_range(0, 7) == 0);
         req = req ^ flip;
         rst_n = ($urandom_range(0, 199) != 0);
         lock = ($urandom_range(0, 3) == 0);
         cyc();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
